// File: rtl/pc_redirect_unit.sv
// ---------------------------------------------------------------------------
// pc_redirect_unit
//
// Program-counter register and branch-redirect controller at the head of IF.
// A taken, word-aligned branch from EX loads the PC with the branch target.
// The IF/ID and ID/EX registers are then squashed for FLUSH_CYCLES cycles.
// A taken branch to a misaligned target does not redirect. Instead it raises
// a sticky error flag.
//
// Parameters
//   RESET_PC      PC value loaded on reset
//   PC_STEP       sequential PC increment in bytes
//   FLUSH_CYCLES  cycles the flush outputs stay high after a redirect (1..7)
//
// Ports
//   clk            in   rising-edge clock
//   reset_n        in   asynchronous active-low reset
//   stall          in   hazard-unit hold, PC keeps its value
//   branch_valid   in   EX holds a conditional branch this cycle
//   select_mux     in   branch taken decision from the branch unit selector
//   branch_target  in   64-bit target address computed in EX
//   pc_out         out  current fetch PC
//   flush_if_id    out  squash IF/ID register
//   flush_id_ex    out  squash ID/EX register
//   redirect       out  one-cycle pulse, PC was loaded from the target
//   misaligned_err out  sticky, a taken branch had a non-word-aligned target
//   taken_count    out  saturating count of accepted redirects
// ---------------------------------------------------------------------------
module pc_redirect_unit #(
  parameter logic [63:0] RESET_PC     = 64'h0,
  parameter int unsigned PC_STEP      = 4,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branch_valid,
  input  logic        select_mux,
  input  logic [63:0] branch_target,
  output logic [63:0] pc_out,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        redirect,
  output logic        misaligned_err,
  output logic [31:0] taken_count
);

  typedef enum logic {
    RUN,
    SQUASH
  } state_t;

  localparam logic [2:0]  SQ_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [63:0] STEP    = 64'(PC_STEP);

  state_t      state_q, state_d;
  logic [2:0]  sq_cnt_q, sq_cnt_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] count_q, count_d;
  logic        err_q, err_d;
  logic        flush_q;
  logic        redirect_q;

  logic taken;
  logic in_run;
  logic aligned;
  logic accept;
  logic misalign;

  // Decide what happens this cycle.
  // Branch requests are only honoured in RUN, because during SQUASH they come
  // from wrong-path instructions. The target is used only on an accepted
  // redirect. So an unknown target on a not-taken cycle never reaches the PC.
  always_comb begin
    taken    = branch_valid & select_mux;
    in_run   = (state_q == RUN);
    aligned  = (branch_target[1:0] == 2'b00);
    accept   = in_run & taken & aligned;
    misalign = in_run & taken & ~aligned;

    pc_d = pc_q + STEP;
    if (accept) begin
      pc_d = branch_target;
    end else if (stall) begin
      pc_d = pc_q;
    end

    state_d  = state_q;
    sq_cnt_d = sq_cnt_q;
    case (state_q)
      RUN: begin
        if (accept) begin
          state_d  = SQUASH;
          sq_cnt_d = SQ_LOAD;
        end
      end
      SQUASH: begin
        // The squash window counts down through stalls.
        // The cycle with a zero count is the last SQUASH cycle.
        if (sq_cnt_q == 3'd0) begin
          state_d = RUN;
        end else begin
          sq_cnt_d = sq_cnt_q - 3'd1;
        end
      end
      default: begin
        state_d  = RUN;
        sq_cnt_d = 3'd0;
      end
    endcase

    count_d = count_q;
    if (accept && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end

    err_d = err_q | misalign;
  end

  // All state and outputs are registered.
  // Reset clears everything at once, even in the middle of a squash window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      sq_cnt_q   <= 3'd0;
      pc_q       <= RESET_PC;
      count_q    <= 32'd0;
      err_q      <= 1'b0;
      flush_q    <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sq_cnt_q   <= sq_cnt_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      err_q      <= err_d;
      flush_q    <= (state_d == SQUASH);
      redirect_q <= accept;
    end
  end

  assign pc_out         = pc_q;
  assign flush_if_id    = flush_q;
  assign flush_id_ex    = flush_q;
  assign redirect       = redirect_q;
  assign misaligned_err = err_q;
  assign taken_count    = count_q;

endmodule
